// File: rtl/kgp_risc_pkg.sv
// Shared constants and the fetch FSM state encoding for the KGP RISC front end.
package kgp_risc_pkg;

  localparam int          ADDR_W    = 32;
  localparam int          INSTR_W   = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          PC_STEP   = 4;
  localparam int          BUF_DEPTH = 2;

  typedef enum logic {
    IFU_IDLE = 1'b0,
    IFU_REQ  = 1'b1
  } ifu_state_e;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO of {PC, instruction} entries with push/pop/flush; flush wins over push.
module ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;
  logic             push_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A full buffer still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok) && !flush;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch PC, single-outstanding instruction-memory reads and a small decode-side buffer.
// Optional IFU_PERF_CNT_EN adds saturating fetch/flush event counters.
import kgp_risc_pkg::*;

module instruction_fetch_unit #(
  parameter int                ADDR_W    = kgp_risc_pkg::ADDR_W,
  parameter int                INSTR_W   = kgp_risc_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(kgp_risc_pkg::RESET_PC),
  parameter int                BUF_DEPTH = kgp_risc_pkg::BUF_DEPTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_next,
  input  logic               pc_load,
  input  logic               halt,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  pc_out
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        flush_count
`endif
);

  localparam int CNT_W   = $clog2(BUF_DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  ifu_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               discard_q, discard_d;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_flush;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   count_after;
  logic               room_after;
  logic [ENTRY_W-1:0] fifo_wr;
  logic [ENTRY_W-1:0] fifo_rd;
  logic               unused_pc_bits;

  assign unused_pc_bits = ^pc_next[1:0];

  ifu_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .wr_data (fifo_wr),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // The tagged PC is the request address, not pc_q, so a redirect cannot mislabel data.
  assign fifo_wr     = {addr_q, imem_rdata};
  assign imem_req    = (state_q == IFU_REQ);
  assign imem_addr   = addr_q;
  assign pc_out      = pc_q;
  assign instr_valid = !fifo_empty;
  assign instr_pc    = fifo_empty ? '0 : fifo_rd[ENTRY_W-1:INSTR_W];
  assign instr_out   = fifo_empty ? '0 : fifo_rd[INSTR_W-1:0];

  always_comb begin
    fifo_pop    = !fifo_empty && instr_ready;
    fifo_flush  = pc_load;
    fifo_push   = (state_q == IFU_REQ) && imem_rvalid && !discard_q && !pc_load;
    count_after = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    room_after  = (count_after < CNT_W'(BUF_DEPTH));
    state_d     = state_q;
    pc_d        = pc_q;
    discard_d   = discard_q;

    if (pc_load) begin
      pc_d = {pc_next[ADDR_W-1:2], 2'b00};
      if ((state_q == IFU_REQ) && !imem_rvalid) begin
        discard_d = 1'b1;
      end else begin
        discard_d = 1'b0;
        state_d   = halt ? IFU_IDLE : IFU_REQ;
      end
    end else if (state_q == IFU_IDLE) begin
      if (!halt && !fifo_full) begin
        state_d = IFU_REQ;
      end
    end else if (imem_rvalid) begin
      if (discard_q) begin
        discard_d = 1'b0;
      end else begin
        pc_d = pc_q + ADDR_W'(PC_STEP);
      end
      state_d = (!halt && room_after) ? IFU_REQ : IFU_IDLE;
    end

    // Address is frozen only while a request is waiting for its data.
    addr_d = ((state_q == IFU_REQ) && !imem_rvalid) ? addr_q : pc_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IFU_IDLE;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      discard_q <= discard_d;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] flush_count_q, flush_count_d;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    fetch_count_d = fifo_push ? sat_inc32(fetch_count_q) : fetch_count_q;
    flush_count_d = pc_load   ? sat_inc32(flush_count_q) : flush_count_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed scenarios, imem responder, decode monitor.
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_next;
  logic        pc_load;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic [31:0] pc_out;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] flush_count;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp       = 0;
  int   n_bad       = 0;
  int   cyc         = 0;
  int   resp_lat    = 0;
  int   resp_budget = 0;
  int   wait_cnt    = 0;
  int   first_pop   = -1;
  int   last_pop    = -1;

  instruction_fetch_unit dut (
    .clock       (clock),
    .reset       (reset),
    .pc_next     (pc_next),
    .pc_load     (pc_load),
    .halt        (halt),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .pc_out      (pc_out)
`ifdef IFU_PERF_CNT_EN
    ,
    .fetch_count (fetch_count),
    .flush_count (flush_count)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem_word(pc);
    exp_q.push_back(e);
  endtask

  // Instruction memory: answers resp_lat cycles after the request, resp_budget times.
  always @(negedge clock) begin
    imem_rvalid = 1'b0;
    if (imem_req && resp_budget > 0) begin
      if (wait_cnt >= resp_lat) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(imem_addr);
        resp_budget--;
        wait_cnt    = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Decode-side monitor: a handshake in a redirect cycle is killed and not delivered.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && instr_valid && instr_ready && !pc_load) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_instr: got pc %h, nothing expected", instr_pc);
      end else begin
        e = exp_q.pop_front();
        check("instr_pc", instr_pc, e.pc);
        check("instr_out", instr_out, e.instr);
      end
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resp_budget = 0;
    pc_load     = 1'b0;
    pc_next     = '0;
    halt        = 1'b0;
    instr_ready = 1'b0;
    reset       = 1'b1;
    step(2);
    exp_q.delete();
    first_pop = -1;
    last_pop  = -1;
  endtask

  task automatic drain(input string name, input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      step(1);
      n++;
    end
    check(name, exp_q.size(), 0);
    step(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, then same-cycle memory with decode always ready.
    do_reset();
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_imem_req", imem_req, 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_instr_valid", instr_valid, 32'h0);
    check("rst_instr_out", instr_out, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    resp_lat = 0; resp_budget = 6; instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) expect_pc(32'(i * 4));
    reset = 1'b0;
    drain("t1_drain", 30);
    check("t1_back_to_back", 32'(last_pop - first_pop), 32'd5);
    check("t1_pc_out", pc_out, 32'd24);

    // Decode stalled: buffer fills to two entries and fetching stops.
    do_reset();
    resp_lat = 0; resp_budget = 5; instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) expect_pc(32'(i * 4));
    reset = 1'b0;
    step(3);
    check("t2_valid", instr_valid, 32'h1);
    check("t2_pc", instr_pc, 32'h0);
    check("t2_out", instr_out, mem_word(32'h0));
    step(7);
    check("t2_req_idle", imem_req, 32'h0);
    check("t2_pc_hold", instr_pc, 32'h0);
    check("t2_out_hold", instr_out, mem_word(32'h0));
    check("t2_pc_out", pc_out, 32'd8);
    instr_ready = 1'b1;
    drain("t2_drain", 30);

    // Redirect while a slow request is outstanding: its data is dropped.
    do_reset();
    resp_lat = 3; resp_budget = 3; instr_ready = 1'b1;
    expect_pc(32'h100);
    expect_pc(32'h104);
    reset = 1'b0;
    step(1);
    check("t3_req", imem_req, 32'h1);
    pc_load = 1'b1; pc_next = 32'h100;
    step(1);
    pc_load = 1'b0;
    check("t3_pc_out", pc_out, 32'h100);
    check("t3_addr_hold", imem_addr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("t3_no_valid", instr_valid, 32'h0);
    end
    check("t3_new_addr", imem_addr, 32'h100);
    check("t3_new_req", imem_req, 32'h1);
    drain("t3_drain", 40);

    // Unaligned redirect coinciding with a pop and a returning word.
    do_reset();
    resp_lat = 0; resp_budget = 5; instr_ready = 1'b1;
    expect_pc(32'h0);
    expect_pc(32'h200);
    expect_pc(32'h204);
    reset = 1'b0;
    step(3);
    check("t4_head_pc", instr_pc, 32'h4);
    pc_load = 1'b1; pc_next = 32'h203;
    step(1);
    pc_load = 1'b0;
    check("t4_pc_out", pc_out, 32'h200);
    check("t4_addr", imem_addr, 32'h200);
    check("t4_flushed", instr_valid, 32'h0);
`ifdef IFU_PERF_CNT_EN
    check("t4_flush_count", flush_count, 32'd1);
`endif
    drain("t4_drain", 30);

    // Halt during a request: it completes, then no new request until halt drops.
    do_reset();
    resp_lat = 2; resp_budget = 3; instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) expect_pc(32'(i * 4));
    reset = 1'b0;
    step(1);
    halt = 1'b1;
    step(3);
    check("t5_pc_out", pc_out, 32'h4);
    for (int i = 0; i < 4; i++) begin
      check("t5_no_req", imem_req, 32'h0);
      step(1);
    end
    halt = 1'b0;
    drain("t5_drain", 40);

    // PC wraps from the top of the address space to zero.
    do_reset();
    resp_lat = 0; resp_budget = 1; instr_ready = 1'b1;
    expect_pc(32'hFFFF_FFFC);
    pc_load = 1'b1; pc_next = 32'hFFFF_FFFC;
    reset = 1'b0;
    step(1);
    pc_load = 1'b0;
    check("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    step(1);
    check("t6_pc_wrap", pc_out, 32'h0);
    check("t6_addr_wrap", imem_addr, 32'h0);
    drain("t6_drain", 20);
`ifdef IFU_PERF_CNT_EN
    check("t6_fetch_count", fetch_count, 32'd1);
    check("t6_flush_count", flush_count, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
